branch_resolve_unit: RTL and testbench

Tracks every conditional branch from ID, where the branch predictor's `predict_taken` is sampled, to MM, where the real outcome is known. Holds in-flight predictions in a small in-order queue, compares each against its resolved outcome, and on a mispredict issues a one-cycle registered flush plus the corrected fetch PC to the IF stage. Sits directly downstream of the branch predictor and alongside the ID→MM pipeline registers.

---
 rtl/branch_resolve_unit.sv | 90 +++++++++
 tb/tb_branch_resolve_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order branch prediction queue from ID to MM, registered mispredict flush and redirect.
// Optional BRU_PERF_EN adds resolve/mispredict counters as output ports.
module branch_resolve_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] FALLTHRU = 32'd8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_push,
  input  logic        id_pred_taken,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_target,
  input  logic        mm_b,
  input  logic        mm_b_taken,
  output logic        q_full,
  output logic        flush,
  output logic [31:0] redirect_pc,
`ifdef BRU_PERF_EN
  output logic [31:0] perf_resolved,
  output logic [31:0] perf_mispredict,
`endif
  output logic        err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic          pred_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   tgt_q  [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_q, flush_d, err_q, err_d;
  logic [31:0]   redirect_q, redirect_d;
  logic          act, empty, push, pop, mis;
  always_comb begin
    act        = !flush_q;
    empty      = cnt_q == '0;
    q_full     = cnt_q == CW'(DEPTH);
    pop        = act && mm_b && !empty;
    mis        = pop && (pred_q[rd_ptr_q] != mm_b_taken);
    push       = act && id_push && (!q_full || pop) && !mis;
    err_d      = err_q || (act && id_push && q_full && !pop) || (act && mm_b && empty);
    flush_d    = mis;
    redirect_d = !mis ? redirect_q : mm_b_taken ? tgt_q[rd_ptr_q] : pc_q[rd_ptr_q] + FALLTHRU;
    wr_ptr_d   = mis ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d   = mis ? '0 : rd_ptr_q + PW'(pop);
    cnt_d      = mis ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  // Payload storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pred_q[wr_ptr_q] <= id_pred_taken;
      pc_q[wr_ptr_q]   <= id_pc;
      tgt_q[wr_ptr_q]  <= id_target;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      err_q      <= err_d;
    end
  end
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign err         = err_q;
`ifdef BRU_PERF_EN
  logic [31:0] perf_res_q, perf_mis_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_res_q <= '0;
      perf_mis_q <= '0;
    end else begin
      perf_res_q <= perf_res_q + 32'(pop);
      perf_mis_q <= perf_mis_q + 32'(mis);
    end
  end
  assign perf_resolved   = perf_res_q;
  assign perf_mispredict = perf_mis_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed stimulus; expected redirects are queued and a monitor compares each flush.
module tb_branch_resolve_unit;
  logic        clk, resetn, id_push, id_pred_taken, mm_b, mm_b_taken;
  logic [31:0] id_pc, id_target;
  logic        q_full, flush, err;
  logic [31:0] redirect_pc;
`ifdef BRU_PERF_EN
  logic [31:0] perf_resolved, perf_mispredict;
`endif
  logic [31:0] exp_q [$];
  int checks, failures;
  branch_resolve_unit #(.DEPTH(4), .FALLTHRU(32'd8)) dut (
    .clk(clk), .resetn(resetn), .id_push(id_push), .id_pred_taken(id_pred_taken),
    .id_pc(id_pc), .id_target(id_target), .mm_b(mm_b), .mm_b_taken(mm_b_taken),
    .q_full(q_full), .flush(flush), .redirect_pc(redirect_pc),
`ifdef BRU_PERF_EN
    .perf_resolved(perf_resolved), .perf_mispredict(perf_mispredict),
`endif
    .err(err)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic monitor();
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn && flush) begin
        chk("flush_back_to_back", {31'b0, prev}, 32'd0);
        if (exp_q.size() == 0) chk("unexpected_flush", {31'b0, flush}, 32'd0);
        else chk("redirect_pc", redirect_pc, exp_q.pop_front());
      end
      prev = resetn && flush;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic p, input logic pred, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic b, input logic taken);
    id_push = p; id_pred_taken = pred; id_pc = pc; id_target = tgt; mm_b = b; mm_b_taken = taken;
    tick();
    id_push = 0; id_pred_taken = 0; id_pc = 0; id_target = 0; mm_b = 0; mm_b_taken = 0;
  endtask
  task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    drive(1, pred, pc, tgt, 0, 0);
  endtask
  task automatic resolve(input logic taken);
    drive(0, 0, 0, 0, 1, taken);
  endtask
  task automatic do_reset();
    resetn = 0;
    tick();
    tick();
    resetn = 1;
  endtask
  initial begin
    checks = 0; failures = 0;
    resetn = 0; id_push = 0; id_pred_taken = 0; id_pc = 0; id_target = 0; mm_b = 0; mm_b_taken = 0;
    fork monitor(); join_none
    do_reset();
    chk("reset_flush", flush, 0);
    chk("reset_redirect", redirect_pc, 0);
    chk("reset_err", err, 0);
    chk("reset_q_full", q_full, 0);
    // correct prediction: nothing happens
    push(32'h100, 32'h200, 1);
    resolve(1);
    tick();
    chk("correct_err", err, 0);
    chk("correct_q_full", q_full, 0);
    // mispredict not-taken -> taken target
    push(32'h100, 32'h200, 0);
    exp_q.push_back(32'h200);
    resolve(1);
    chk("mis_flush_high", flush, 1);
    tick();
    chk("mis_flush_low", flush, 0);
    push(32'h500, 32'h600, 1);
    resolve(1);
    tick();
    chk("redirect_hold", redirect_pc, 32'h200);
    // mispredict with younger entries in flight
    push(32'h300, 32'h400, 1);
    push(32'h310, 32'h410, 0);
    push(32'h320, 32'h420, 1);
    push(32'h330, 32'h430, 0);
    chk("four_full", q_full, 1);
    exp_q.push_back(32'h308);
    resolve(0);
    chk("discard_flush", flush, 1);
    tick();
    chk("discard_empty", q_full, 0);
    // full, overflow, push+pop at full
    push(32'h1000, 32'h2000, 1);
    push(32'h1010, 32'h2010, 0);
    push(32'h1020, 32'h2020, 1);
    chk("three_not_full", q_full, 0);
    push(32'h1030, 32'h2030, 1);
    chk("full_q_full", q_full, 1);
    chk("full_no_err", err, 0);
    push(32'h1040, 32'h2040, 1);
    chk("overflow_err", err, 1);
    chk("overflow_full", q_full, 1);
    drive(1, 0, 32'h1050, 32'h2050, 1, 1);
    chk("pushpop_full", q_full, 1);
    chk("pushpop_no_flush", flush, 0);
    resolve(0);
    resolve(1);
    resolve(1);
    chk("drain_not_full", q_full, 0);
    exp_q.push_back(32'h2050);
    resolve(1);
    chk("last_mis_flush", flush, 1);
    tick();
    chk("err_sticky", err, 1);
    do_reset();
    chk("reset2_err", err, 0);
    chk("reset2_redirect", redirect_pc, 0);
    // underflow
    resolve(1);
    chk("underflow_err", err, 1);
    chk("underflow_no_flush", flush, 0);
    tick();
    chk("underflow_no_flush2", flush, 0);
    do_reset();
    chk("reset3_err", err, 0);
    // mispredict drops a simultaneous push; inputs ignored during flush
    push(32'h700, 32'h800, 0);
    exp_q.push_back(32'h800);
    drive(1, 1, 32'h710, 32'h810, 1, 1);
    chk("drop_flush", flush, 1);
    drive(1, 1, 32'h720, 32'h820, 1, 1);
    chk("flush_cycle_no_err", err, 0);
    resolve(1);
    chk("drop_queue_empty", err, 1);
    do_reset();
    // fall-through address wraps at 32 bits
    push(32'hFFFF_FFFC, 32'h0, 1);
    exp_q.push_back(32'h4);
    resolve(0);
    tick();
    // reset on the mispredict edge suppresses the flush
    push(32'h900, 32'hA00, 0);
    resetn = 0;
    resolve(1);
    chk("rst_mid_flush", flush, 0);
    chk("rst_mid_redirect", redirect_pc, 0);
    resetn = 1;
    tick();
`ifdef BRU_PERF_EN
    push(32'h10, 32'h20, 1); resolve(1);
    push(32'h30, 32'h40, 0); exp_q.push_back(32'h40); resolve(1); tick();
    push(32'h50, 32'h60, 1); resolve(1);
    push(32'h70, 32'h80, 1); exp_q.push_back(32'h78); resolve(0); tick();
    push(32'h90, 32'hA0, 0); resolve(0);
    chk("perf_resolved", perf_resolved, 5);
    chk("perf_mispredict", perf_mispredict, 2);
`endif
    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
